// File: rtl/bus_sel_pkg.sv
// Shared constants, types and helpers for the bus select encoder.
// Optional round-robin priority is enabled with the BUS_SEL_ROUND_ROBIN_EN macro.
package bus_sel_pkg;

    // Index width for a vector of 'value' lines; never below 1 bit.
    function automatic int clog2_f(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    localparam int DEF_N         = 32;
    localparam int DEF_ERR_CNT_W = 8;

    localparam int FLAG_W     = 2;
    localparam int FLAG_MULTI = 0;
    localparam int FLAG_NONE  = 1;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

endpackage

// File: rtl/bus_select_encoder_if.sv
// Request/select handshake bundle for bus_select_encoder, plus debug visibility
// of the output buffer state and the priority pointer.
interface bus_select_encoder_if
    import bus_sel_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int ERR_CNT_W = DEF_ERR_CNT_W
);
    localparam int SEL_W = clog2_f(N);

    // Valid/ready: a transfer happens on a rising edge where valid and ready
    // are both 1; valid never waits on ready, and the producer holds its data
    // stable until the transfer completes.
    logic [N-1:0]         req;
    logic                 req_valid;
    logic                 req_ready;
    logic [SEL_W-1:0]     sel;
    logic                 sel_valid;
    logic                 sel_ready;
    logic                 multi_hot;
    logic                 none_hot;
    logic [ERR_CNT_W-1:0] err_count;
    buf_state_e           dbg_state;
    logic [SEL_W-1:0]     dbg_ptr;

    modport master (
        output req, req_valid, sel_ready,
        input  req_ready, sel, sel_valid, multi_hot, none_hot, err_count,
               dbg_state, dbg_ptr
    );

    modport slave (
        input  req, req_valid, sel_ready,
        output req_ready, sel, sel_valid, multi_hot, none_hot, err_count,
               dbg_state, dbg_ptr
    );

endinterface

// File: rtl/bus_sel_find.sv
// Combinational find-first-set over an N-bit vector, searching upward from
// 'start' and wrapping from N-1 back to 0.
module bus_sel_find
    import bus_sel_pkg::*;
#(
    parameter int N = DEF_N,
    localparam int SEL_W = clog2_f(N)
) (
    input  logic [N-1:0]     vec,
    input  logic [SEL_W-1:0] start,
    output logic [SEL_W-1:0] idx,
    output logic             any_set,
    output logic             multi_set
);
    localparam logic [N-1:0]   ONE   = {{(N-1){1'b0}}, 1'b1};
    localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(N);

    // One extra bit so start+i cannot overflow before the modulo fold.
    logic [SEL_W:0] pos;
    logic           found;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int i = 0; i < N; i++) begin
            pos = {1'b0, start} + (SEL_W+1)'(i);
            if (pos >= N_EXT) pos = pos - N_EXT;
            if (!found && vec[pos[SEL_W-1:0]]) begin
                found = 1'b1;
                idx   = pos[SEL_W-1:0];
            end
        end
    end

    assign any_set   = |vec;
    assign multi_set = |(vec & (vec - ONE));

endmodule

// File: rtl/bus_select_encoder.sv
// Registered request-vector to bus-select encoder with a one-entry output
// buffer and malformed-request counting. Define BUS_SEL_ROUND_ROBIN_EN for
// rotating multi-hot priority; otherwise the lowest set index wins.
module bus_select_encoder
    import bus_sel_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int ERR_CNT_W = DEF_ERR_CNT_W
) (
    input logic                 clk,
    input logic                 clr,
    bus_select_encoder_if.slave bus
);
    localparam int SEL_W = clog2_f(N);

    buf_state_e           state_q, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [FLAG_W-1:0]    flags_q, flags_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;

    logic [SEL_W-1:0] start;
    logic [SEL_W-1:0] win_idx;
    logic             win_any;
    logic             win_multi;
    logic             req_ready;
    logic             accept;

    assign req_ready = (state_q == BUF_EMPTY) || bus.sel_ready;
    assign accept    = bus.req_valid && req_ready;

    bus_sel_find #(.N(N)) u_find (
        .vec       (bus.req),
        .start     (start),
        .idx       (win_idx),
        .any_set   (win_any),
        .multi_set (win_multi)
    );

`ifdef BUS_SEL_ROUND_ROBIN_EN
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W:0]   ptr_inc;

    // Next search begins just past the last winner, folded modulo N.
    always_comb begin
        ptr_inc = {1'b0, win_idx} + {{SEL_W{1'b0}}, 1'b1};
        ptr_d   = ptr_q;
        if (accept && win_any) begin
            ptr_d = (ptr_inc == (SEL_W+1)'(N)) ? '0 : ptr_inc[SEL_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (clr) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    assign start = ptr_q;
`else
    assign start = '0;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        flags_d = flags_q;
        err_d   = err_q;
        if (accept) begin
            state_d             = BUF_FULL;
            sel_d               = win_idx;
            flags_d[FLAG_MULTI] = win_multi;
            flags_d[FLAG_NONE]  = !win_any;
            if ((win_multi || !win_any) && (err_q != '1)) begin
                err_d = err_q + ERR_CNT_W'(1);
            end
        end else if ((state_q == BUF_FULL) && bus.sel_ready) begin
            state_d = BUF_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= BUF_EMPTY;
            sel_q   <= '0;
            flags_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            flags_q <= flags_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.sel       = sel_q;
    assign bus.sel_valid = (state_q == BUF_FULL);
    assign bus.multi_hot = flags_q[FLAG_MULTI];
    assign bus.none_hot  = flags_q[FLAG_NONE];
    assign bus.err_count = err_q;
    assign bus.dbg_state = state_q;
    assign bus.dbg_ptr   = start;

endmodule

// File: doc/bus_select_encoder.md
Name: bus_select_encoder

Overview:
- Parametrised, registered successor to the bus one-hot encoder in the Mini SRC datapath.
- Converts an N-bit register-out/drive request vector into a binary bus-select index.
- Adds a valid/ready handshake, a one-entry output buffer and multi-hot/no-hot detection with a saturating error counter.
- Sits between the control unit's drive-enable lines and the bus multiplexer select input.

Parameters:
- N, 32, number of request lines (2..64).
- SEL_W, $clog2(N), width of the encoded index. Derived localparam; not overridable.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  synchronous, active-high reset.
- req  input  N  request vector; one-hot is expected.
- req_valid  input  1  req is presented this cycle.
- req_ready  output  1  block accepts req this cycle.
- sel  output  SEL_W  encoded winning index.
- sel_valid  output  1  sel and flags are valid.
- sel_ready  input  1  consumer takes sel this cycle.
- multi_hot  output  1  accepted req had more than one bit set.
- none_hot  output  1  accepted req was all zero.
- err_count  output  ERR_CNT_W  saturating count of malformed accepted requests.

Behaviour:
- Reset (clr=1 at posedge): sel=0, sel_valid=0, multi_hot=0, none_hot=0, err_count=0, priority pointer ptr=0.
- clr takes priority over every other event. Any buffered entry is discarded.
- req_ready = !sel_valid || sel_ready. This is combinational; there is no combinational path from req to sel.
- Accept = req_valid && req_ready.
- Latency: sel, flags and sel_valid update at the posedge after accept (1 cycle).
- Output buffer states:
  - EMPTY (sel_valid=0):
    - Accept -> FULL.
    - No accept -> stay EMPTY.
  - FULL (sel_valid=1):
    - sel_ready && accept -> stay FULL and load new data (back-to-back, full throughput).
    - sel_ready && no accept -> EMPTY.
    - No sel_ready -> hold all outputs stable. req_ready=0.
- Encoding:
  - Exactly one bit k set: sel=k, multi_hot=0, none_hot=0.
  - Multiple bits set: sel = the first set bit found by the priority search; multi_hot=1.
  - req==0: sel=0, none_hot=1, sel_valid still asserts. No X is ever driven.
- Fixed-priority search, lowest index first: the default when the optional feature is off.
- err_count increments by 1 on each accepted multi_hot or none_hot request. It saturates at 2^ERR_CNT_W-1 and never wraps.
- Flags are qualified by sel_valid. While sel_valid=0 they hold their last values.
- Index arithmetic is modulo N for non-power-of-two N. The search wraps from N-1 to 0.

Optional Feature:
- Macro: BUS_SEL_ROUND_ROBIN_EN.
- Defined:
  - The multi-hot search starts at ptr and wraps.
  - On every accepted non-zero req, ptr <= (winner+1) mod N.
  - One-hot results are unaffected.
- Undefined: ptr logic is absent; fixed lowest-index priority applies.

Decomposition:
- Shared package bus_sel_pkg holds:
  - the clog2 constant function,
  - the default N and ERR_CNT_W constants,
  - the flag-bit encoding constants.
- One sub-module, bus_sel_find: combinational find-first-set from a start index, with wrap. It outputs the index, any_set and multi_set. Reused by both priority modes; start is tied to 0 when the feature is off.

Test Plan:
- Reset, then req=32'h0000_0400 with req_valid=1 and sel_ready=1 -> next cycle sel=10, sel_valid=1, flags 0, err_count=0.
- Sweep all 32 one-hot values back-to-back with sel_ready held 1 -> sel=0..31 on consecutive cycles, no bubbles, req_ready stays 1.
- req=32'h8000_0011 -> sel=0, multi_hot=1, err_count=1. With BUS_SEL_ROUND_ROBIN_EN, repeating the same req three times -> sel=0, 4, 31.
- req=0 accepted -> sel=0, none_hot=1, err_count increments. Drive 300 malformed requests with ERR_CNT_W=8 -> err_count=255 and it holds.
- Backpressure: FULL with sel=5 and sel_ready=0 for 4 cycles while req changes -> sel stays 5, req_ready=0. sel_ready then goes 1 -> the next req is accepted in that same cycle.
- clr asserted while FULL with sel_ready=0 -> next cycle sel_valid=0, sel=0, err_count=0, ptr=0.
